// File: rtl/snake_game_sequencer.sv
// -----------------------------------------------------------------------------
// snake_game_sequencer
//
// Game-flow controller for the snake datapath. It sequences start/restart via
// a one-cycle sync strobe, owns the active body length, runs a serial
// self-collision scan (one segment per cycle) after every movement tick,
// checks for an eaten apple, grows the snake and reports game-over / win.
//
// Optional feature macro: WALL_COLLIDE_EN
//   defined   : a head on the border (x or y equal to 0 or 15) ends the game
//   undefined : the border is ignored (the body updater wraps around)
//
// Ports
//   clk          in   system clock
//   nrst         in   asynchronous active-low reset
//   start        in   single-cycle start/restart pulse (already synchronized)
//   pulse        in   single-cycle movement tick from the clock divider
//   body         in   MAX_LENGTH packed segments {x[3:0], y[3:0]}, [0] = head
//   apple        in   apple location {x, y}
//   curr_length  out  active segment count
//   sync         out  one-cycle restart strobe
//   apple_new    out  one-cycle request for a new apple
//   running      out  high in RUN, SETTLE, SCAN and EAT
//   game_over    out  high in OVER
//   win          out  high in OVER when the max length was reached
// -----------------------------------------------------------------------------
module snake_game_sequencer #(
   parameter int MAX_LENGTH  = 50,
   parameter int INIT_LENGTH = 2
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       start,
   input  logic                       pulse,
   input  logic [MAX_LENGTH-1:0][7:0] body,
   input  logic [7:0]                 apple,
   output logic [6:0]                 curr_length,
   output logic                       sync,
   output logic                       apple_new,
   output logic                       running,
   output logic                       game_over,
   output logic                       win
);

   localparam logic [6:0] MAX_LEN_C  = 7'(MAX_LENGTH);
   localparam logic [6:0] INIT_LEN_C = 7'(INIT_LENGTH);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SCAN   = 3'd3,
      ST_EAT    = 3'd4,
      ST_OVER   = 3'd5
   } state_e;

   state_e     state_q, state_d;
   logic [6:0] idx_q, idx_d;
   logic [6:0] len_q, len_d;
   logic       win_q, win_d;
   logic       sync_q, sync_d;
   logic       apple_new_q, apple_new_d;
   logic       running_q, running_d;
   logic       game_over_q, game_over_d;
   logic [7:0] seg_s;
   logic       wall_hit_s;

`ifdef WALL_COLLIDE_EN
   // True when a segment sits on any of the four border lines.
   function automatic logic on_wall(input logic [7:0] seg);
      return (seg[7:4] == 4'h0) || (seg[7:4] == 4'hF) ||
             (seg[3:0] == 4'h0) || (seg[3:0] == 4'hF);
   endfunction

   assign wall_hit_s = on_wall(body[0]);
`else
   assign wall_hit_s = 1'b0;
`endif

   // Select the segment under test; a compare-mux keeps the 7-bit index
   // independent of the array depth.
   always_comb begin
      seg_s = body[0];
      for (int i = 0; i < MAX_LENGTH; i++) begin
         seg_s = (idx_q == 7'(i)) ? body[i] : seg_s;
      end
   end

   // Next-state, counters and registered-output next values.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      len_d       = len_q;
      win_d       = win_q;
      sync_d      = 1'b0;
      apple_new_d = 1'b0;
      if (start) begin
         // Restart wins over every other event, including a tick on the same edge.
         state_d = ST_RUN;
         idx_d   = 7'd0;
         len_d   = INIT_LEN_C;
         win_d   = 1'b0;
         sync_d  = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_OVER: begin
               state_d = state_q;
            end
            ST_RUN: begin
               if (pulse) begin
                  state_d = ST_SETTLE;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_SETTLE: begin
               if (wall_hit_s) begin
                  state_d = ST_OVER;
                  win_d   = 1'b0;
               end else if (len_q == 7'd1) begin
                  state_d = ST_EAT;
               end else begin
                  idx_d   = 7'd1;
                  state_d = ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (seg_s == body[0]) begin
                  state_d = ST_OVER;
                  win_d   = 1'b0;
               end else if (idx_q == (len_q - 7'd1)) begin
                  state_d = ST_EAT;
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
            ST_EAT: begin
               if (body[0] == apple) begin
                  apple_new_d = 1'b1;
                  len_d       = len_q + 7'd1;
                  if ((len_q + 7'd1) == MAX_LEN_C) begin
                     state_d = ST_OVER;
                     win_d   = 1'b1;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_IDLE;
               idx_d   = 7'd0;
            end
         endcase
      end
      running_d   = (state_d == ST_RUN) || (state_d == ST_SETTLE) ||
                    (state_d == ST_SCAN) || (state_d == ST_EAT);
      game_over_d = (state_d == ST_OVER);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= ST_IDLE;
         idx_q       <= 7'd0;
         len_q       <= INIT_LEN_C;
         win_q       <= 1'b0;
         sync_q      <= 1'b0;
         apple_new_q <= 1'b0;
         running_q   <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         win_q       <= win_d;
         sync_q      <= sync_d;
         apple_new_q <= apple_new_d;
         running_q   <= running_d;
         game_over_q <= game_over_d;
      end
   end

   assign curr_length = len_q;
   assign sync        = sync_q;
   assign apple_new   = apple_new_q;
   assign running     = running_q;
   assign game_over   = game_over_q;
   assign win         = win_q;

endmodule
